// File: rtl/mult4_seq_pkg.sv
// Shared definitions for the sequential 4x4 shift-and-add multiplier.
package mult4_seq_pkg;

  localparam int unsigned N_ITER = 4;
  localparam int unsigned PW     = 8;
  localparam int unsigned CW     = $clog2(N_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/adder4.sv
// 4-bit ripple-carry adder: four full-adder stages chained through the carry.
module adder4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    Sum  = '0;
    c[0] = Cin;
    for (int unsigned i = 0; i < 4; i++) begin
      Sum[i]   = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Cout = c[4];
  end

endmodule

// File: rtl/mult4_seq.sv
// Sequential 4x4 unsigned multiplier: one add/shift iteration per clock on adder4,
// 8-bit product with a one-cycle Done pulse.
module mult4_seq
  import mult4_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Start,
  input  logic [3:0]    A,
  input  logic [3:0]    B,
  output logic          Busy,
  output logic          Done,
  output logic [PW-1:0] Product
);

  state_t          state_q, state_d;
  logic [3:0]      mcand_q, mcand_d;
  logic [3:0]      acc_q, acc_d;
  logic [3:0]      q_q, q_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_q, product_d;

  logic [3:0]      addend;
  logic [3:0]      sum;
  logic            cout;

  assign addend = q_q[0] ? mcand_q : '0;

  adder4 u_adder4 (
    .A    (acc_q),
    .B    (addend),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          mcand_d = A;
          q_d     = B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // Carry-out becomes the new MSB of Acc, so no overflow is ever lost.
        acc_d = {cout, sum[3:1]};
        q_d   = {sum[0], q_q[3:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N_ITER - 1)) begin
          product_d = {cout, sum, q_q[3:1]};
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign Busy    = (state_q == CALC);
  assign Done    = (state_q == DONE);
  assign Product = product_q;

endmodule

// File: tb/tb_mult4_seq.sv
// Self-checking bench for mult4_seq: expected products queued at each accepted Start.
module tb_mult4_seq;

  logic       clk;
  logic       rst_n;
  logic       Start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Busy;
  logic       Done;
  logic [7:0] Product;

  typedef struct {
    logic [7:0]  prod;
    int unsigned acc_cyc;
  } sb_t;

  sb_t         sbq[$];
  sb_t         e;
  int unsigned cyc;
  int unsigned n_cmp;
  int unsigned n_err;

  mult4_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .Product (Product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding request, 4 cycles after acceptance.
  always @(negedge clk) begin
    if (Done) begin
      check("done_pending", {31'b0, sbq.size() != 0}, 32'd1);
      check("busy_done_excl", {31'b0, Busy}, 32'd0);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("product", {24'b0, Product}, {24'b0, e.prod});
        check("latency", cyc - e.acc_cyc, 32'd4);
      end
    end
  end

  // Caller is at a negedge; drives Start for exactly one rising edge.
  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    sb_t s;
    Start = 1'b1;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    s.prod    = 8'(a) * 8'(b);
    s.acc_cyc = cyc;
    sbq.push_back(s);
    Start = 1'b0;
    A     = 4'($urandom);
    B     = 4'($urandom);
  endtask

  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    issue(a, b);
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("drain_timeout", sbq.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    Start = 1'b0;
    A     = '0;
    B     = '0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_done", {31'b0, Done}, 32'd0);
    check("rst_product", {24'b0, Product}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'b0, Busy}, 32'd0);

    // 15*15 with cycle-by-cycle status checks
    start_op(4'd15, 4'd15);
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      check("max_busy_calc", {31'b0, Busy}, 32'd1);
      check("max_done_calc", {31'b0, Done}, 32'd0);
    end
    @(negedge clk);
    check("max_done_e4", {31'b0, Done}, 32'd1);
    check("max_busy_e4", {31'b0, Busy}, 32'd0);
    check("max_prod_e4", {24'b0, Product}, 32'hE1);
    @(negedge clk);
    check("max_done_e5", {31'b0, Done}, 32'd0);
    check("max_prod_hold", {24'b0, Product}, 32'hE1);

    start_op(4'd9, 4'd6);   wait_drain();
    start_op(4'd0, 4'd13);  wait_drain();
    start_op(4'd13, 4'd0);  wait_drain();
    start_op(4'd1, 4'd1);   wait_drain();

    // Start during CALC at E2 must be ignored
    start_op(4'd3, 4'd5);
    @(negedge clk);
    @(negedge clk);
    Start = 1'b1;
    A     = 4'd15;
    B     = 4'd15;
    @(posedge clk);
    #1 Start = 1'b0;
    wait_drain();
    check("ignored_prod", {24'b0, Product}, 32'h0F);
    repeat (8) @(negedge clk);

    // Back-to-back through the DONE cycle
    start_op(4'd7, 4'd7);
    repeat (4) @(negedge clk);
    @(negedge clk);
    check("b2b_busy_done", {31'b0, Busy}, 32'd0);
    check("b2b_done", {31'b0, Done}, 32'd1);
    issue(4'd2, 4'd8);
    @(negedge clk);
    check("b2b_busy_again", {31'b0, Busy}, 32'd1);
    wait_drain();
    check("b2b_prod", {24'b0, Product}, 32'h10);

    // Asynchronous reset between E2 and E3
    start_op(4'd6, 4'd7);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sbq.delete();
    check("arst_busy", {31'b0, Busy}, 32'd0);
    check("arst_done", {31'b0, Done}, 32'd0);
    check("arst_product", {24'b0, Product}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("arst_prod_after", {24'b0, Product}, 32'd0);
    start_op(4'd11, 4'd12);
    wait_drain();

    // All 256 pairs, random gaps including back-to-back
    for (int unsigned a = 0; a < 16; a++) begin
      for (int unsigned b = 0; b < 16; b++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        start_op(4'(a), 4'(b));
        repeat (4) @(negedge clk);
      end
    end
    wait_drain();
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
